// File: rtl/dnn_pkg.sv
// Shared types and width/index helpers for the time-multiplexed dense network.
package dnn_pkg;

    typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_e;

    function automatic int hw_f(int dw, int n_in);
        return 2*dw + $clog2(n_in);
    endfunction

    function automatic int ow_f(int dw, int n_in, int n_hid);
        return hw_f(dw, n_in) + dw + $clog2(n_hid);
    endfunction

    // Counter width that stays legal for a dimension of 1.
    function automatic int cw_f(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB of element [r][c] in a row-major flat bus.
    function automatic int lsb2d(int r, int c, int ncol, int dw);
        return (r*ncol + c) * dw;
    endfunction

endpackage

// File: rtl/dnn_mac.sv
// Signed multiply-accumulate: sum = acc + a*b is exposed combinationally.
module dnn_mac #(
    parameter int DW = 5,
    parameter int MW = 12,
    parameter int OW = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] a,
    input  logic signed [MW-1:0] b,
    output logic signed [OW-1:0] sum
);

    localparam int PW = DW + MW;

    logic signed [PW-1:0] prod;
    logic signed [OW-1:0] acc_q, acc_d;

    assign prod = PW'(a) * PW'(b);
    assign sum  = acc_q + OW'(prod);

    // Clear wins over accumulate so the closing step of a dot product restarts at zero.
    always_comb begin
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (en)
            acc_d = sum;
    end

    always_ff @(posedge clk) begin
        if (rst)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

endmodule

// File: rtl/dnn_seq.sv
// Two-layer dense network (input -> hidden with optional ReLU -> output)
// evaluated one product per cycle on a single MAC.
module dnn_seq
    import dnn_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_HID = 4,
    parameter int N_OUT = 2,
    parameter int DW    = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            relu_en,
    input  logic [N_IN*DW-1:0]              x_in,
    input  logic [N_IN*N_HID*DW-1:0]        w1_in,
    input  logic [N_HID*N_OUT*DW-1:0]       w2_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [N_OUT*ow_f(DW,N_IN,N_HID)-1:0] out_data
);

    localparam int HW = hw_f(DW, N_IN);
    localparam int OW = ow_f(DW, N_IN, N_HID);
    localparam int MW = (HW > DW) ? HW : DW;
    localparam int IW = cw_f(N_IN);
    localparam int JW = cw_f(N_HID);
    localparam int KW = cw_f(N_OUT);

    state_e                      state_q, state_d;
    logic [N_IN*DW-1:0]          x_q, x_d;
    logic [N_IN*N_HID*DW-1:0]    w1_q, w1_d;
    logic [N_HID*N_OUT*DW-1:0]   w2_q, w2_d;
    logic                        relu_q, relu_d;
    logic [IW-1:0]               i_q, i_d;
    logic [JW-1:0]               j_q, j_d;
    logic [KW-1:0]               k_q, k_d;
    logic [N_HID-1:0][HW-1:0]    h_q, h_d;
    logic [N_OUT-1:0][OW-1:0]    out_q, out_d;

    logic                        mac_clr, mac_en;
    logic signed [DW-1:0]        mac_a;
    logic signed [MW-1:0]        mac_b;
    logic signed [OW-1:0]        mac_sum;
    logic signed [DW-1:0]        x_sel;
    logic signed [HW-1:0]        h_sel;

    dnn_mac #(.DW(DW), .MW(MW), .OW(OW)) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (mac_a),
        .b   (mac_b),
        .sum (mac_sum)
    );

    assign x_sel     = x_q[int'(i_q)*DW +: DW];
    assign h_sel     = h_q[j_q];
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        relu_d  = relu_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        h_d     = h_q;
        out_d   = out_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        mac_a   = '0;
        mac_b   = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x_in;
                    w1_d    = w1_in;
                    w2_d    = w2_in;
                    relu_d  = relu_en;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    mac_clr = 1'b1;
                    state_d = L1;
                end
            end
            L1: begin
                mac_a  = w1_q[lsb2d(int'(i_q), int'(j_q), N_HID, DW) +: DW];
                mac_b  = MW'(x_sel);
                mac_en = 1'b1;
                if (i_q == IW'(N_IN-1)) begin
                    h_d[j_q] = (relu_q && mac_sum[OW-1]) ? '0 : mac_sum[HW-1:0];
                    mac_clr  = 1'b1;
                    i_d      = '0;
                    if (j_q == JW'(N_HID-1)) begin
                        j_d     = '0;
                        state_d = L2;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            L2: begin
                mac_a  = w2_q[lsb2d(int'(j_q), int'(k_q), N_OUT, DW) +: DW];
                mac_b  = MW'(h_sel);
                mac_en = 1'b1;
                if (j_q == JW'(N_HID-1)) begin
                    out_d[k_q] = mac_sum;
                    mac_clr    = 1'b1;
                    j_d        = '0;
                    if (k_q == KW'(N_OUT-1)) begin
                        k_d     = '0;
                        state_d = DONE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            relu_q  <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            h_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            relu_q  <= relu_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            h_q     <= h_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_dnn_seq.sv
// Directed bench for dnn_seq with an integer reference model and per-cycle result checking.
module tb_dnn_seq;

    localparam int N_IN  = 4;
    localparam int N_HID = 4;
    localparam int N_OUT = 2;
    localparam int DW    = 5;
    localparam int HW    = 2*DW + $clog2(N_IN);
    localparam int OW    = HW + DW + $clog2(N_HID);

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic                      relu_en;
    logic [N_IN*DW-1:0]        x_in;
    logic [N_IN*N_HID*DW-1:0]  w1_in;
    logic [N_HID*N_OUT*DW-1:0] w2_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [N_OUT*OW-1:0]       out_data;

    always #5 clk = ~clk;

    dnn_seq #(.N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .relu_en   (relu_en),
        .x_in      (x_in),
        .w1_in     (w1_in),
        .w2_in     (w2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;

    int   xa [N_IN];
    int   w1a[N_IN][N_HID];
    int   w2a[N_HID][N_OUT];
    logic relu_v;

    logic [N_OUT*OW-1:0] exp_q[$];
    logic                prev_hold = 1'b0;
    logic [N_OUT*OW-1:0] prev_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    // Plain dense-network arithmetic on the operand arrays, packed the way out_data is.
    function automatic logic [N_OUT*OW-1:0] model();
        longint h[N_HID];
        longint o;
        logic [N_OUT*OW-1:0] r;
        r = '0;
        for (int j = 0; j < N_HID; j++) begin
            h[j] = 0;
            for (int i = 0; i < N_IN; i++) h[j] += longint'(xa[i]) * w1a[i][j];
            if (relu_v && h[j] < 0) h[j] = 0;
        end
        for (int k = 0; k < N_OUT; k++) begin
            o = 0;
            for (int j = 0; j < N_HID; j++) o += h[j] * w2a[j][k];
            r[k*OW +: OW] = o[OW-1:0];
        end
        return r;
    endfunction

    task automatic pack();
        for (int i = 0; i < N_IN; i++) x_in[i*DW +: DW] = xa[i][DW-1:0];
        for (int i = 0; i < N_IN; i++)
            for (int j = 0; j < N_HID; j++) w1_in[(i*N_HID+j)*DW +: DW] = w1a[i][j][DW-1:0];
        for (int j = 0; j < N_HID; j++)
            for (int k = 0; k < N_OUT; k++) w2_in[(j*N_OUT+k)*DW +: DW] = w2a[j][k][DW-1:0];
        relu_en = relu_v;
    endtask

    task automatic fill(input int xv, input int w1v, input int w2v, input logic r);
        for (int i = 0; i < N_IN; i++) xa[i] = xv;
        for (int i = 0; i < N_IN; i++) for (int j = 0; j < N_HID; j++) w1a[i][j] = w1v;
        for (int j = 0; j < N_HID; j++) for (int k = 0; k < N_OUT; k++) w2a[j][k] = w2v;
        relu_v = r;
        pack();
    endtask

    task automatic pat(input int n);
        for (int i = 0; i < N_IN; i++) xa[i] = ((i + n) % 5) - 2;
        for (int i = 0; i < N_IN; i++)
            for (int j = 0; j < N_HID; j++) w1a[i][j] = ((i*3 + j + n) % 7) - 3;
        for (int j = 0; j < N_HID; j++)
            for (int k = 0; k < N_OUT; k++) w2a[j][k] = ((j + 2*k + n) % 5) - 2;
        relu_v = n[0];
        pack();
    endtask

    // Per-cycle result checking against the model queue.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    checks++;
                    if (out_data !== exp_q[0]) begin
                        errors++;
                        $display("FAIL result got %h want %h", out_data, exp_q[0]);
                    end
                end
                chk("ready_while_valid", in_ready, 0);
                if (prev_hold) begin
                    checks++;
                    if (out_data !== prev_data) begin
                        errors++;
                        $display("FAIL hold_stable got %h want %h", out_data, prev_data);
                    end
                end
                prev_hold = !out_ready;
                prev_data = out_data;
                if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
                prev_hold = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model());
                acc_cnt++;
                acc_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        chk({nm, "_latency"}, n, 24);
    endtask

    task automatic chk_out(input string nm, input longint l0, input longint l1);
        logic signed [OW-1:0] f0, f1;
        f0 = out_data[0 +: OW];
        f1 = out_data[OW +: OW];
        chk({nm, "_out0"}, f0, l0);
        chk({nm, "_out1"}, f1, l1);
    endtask

    // Called at posedge+1 with the block idle; out_ready held high.
    task automatic run_job(input string nm, input longint l0, input longint l1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({nm, "_accepted"}, in_ready, 0);
        wait_valid(nm);
        chk_out(nm, l0, l1);
        step();
        chk({nm, "_valid_1cyc"}, out_valid, 0);
        chk({nm, "_ready_after"}, in_ready, 1);
    endtask

    initial begin
        int seen, prev, guard;
        int t[4];
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        fill(0, 0, 0, 1'b0);
        repeat (3) step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;

        fill(1, 1, 1, 1'b1);
        run_job("ones", 16, 16);
        fill(-16, 15, 1, 1'b1);
        run_job("relu_on", 0, 0);
        fill(-16, 15, 1, 1'b0);
        run_job("relu_off", -3840, -3840);
        fill(-16, -16, -16, 1'b1);
        run_job("extreme", -65536, -65536);

        // Backpressure with a different job waiting at the input.
        fill(2, -3, 5, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        wait_valid("bp");
        chk_out("bp", -480, -480);
        fill(1, 1, 1, 1'b1);
        in_valid = 1'b1;
        repeat (10) begin
            step();
            chk("bp_valid_held", out_valid, 1);
            chk("bp_no_accept", in_ready, 0);
        end
        chk_out("bp_held", -480, -480);
        out_ready = 1'b1;
        step();
        chk("bp_xfer_valid", out_valid, 0);
        chk("bp_xfer_ready", in_ready, 1);
        step();
        chk("bp_next_accept", in_ready, 0);
        in_valid = 1'b0;
        wait_valid("bp_next");
        chk_out("bp_next", 16, 16);
        step();

        // Reset in the middle of layer 1.
        fill(3, 2, 1, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        chk("midrst_ready", in_ready, 1);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            step();
            seen += int'(out_valid);
        end
        chk("midrst_no_valid", seen, 0);
        run_job("post_rst", 96, 96);

        // Back-to-back jobs with operands changing after each acceptance.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int n = 0; n < 4; n++) begin
            pat(n);
            prev  = acc_cnt;
            guard = 0;
            while (acc_cnt == prev && guard < 60) begin
                step();
                guard++;
            end
            chk("b2b_accept_seen", acc_cnt - prev, 1);
            t[n] = acc_cyc;
            if (n > 0) chk("b2b_period", t[n] - t[n-1], 26);
        end
        in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            step();
            guard++;
        end
        chk("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

endmodule
